// File: rtl/ddl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddl_pkg
//  Brief    : Shared types and helpers for the fractional digital delay line.
//             Optional feature macro used by the design: DDL_TLAST_EN.
//  Revision : 1.0 - initial release
// ============================================================================
package ddl_pkg;

  // Default geometry of the delay line.
  localparam int DDL_NUM_LANES = 16;
  localparam int DDL_SAMPLE_W  = 16;
  localparam int DDL_MAX_DELAY = 255;

  typedef logic [DDL_SAMPLE_W-1:0] sample_t;
  typedef sample_t [DDL_NUM_LANES-1:0] beat_t;

  // Whole-beat part (q) and lane offset (r) of a delay in samples.
  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
  } delay_split_t;

  // Bits needed to index n distinct values (never less than one bit).
  function automatic int ddl_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Split a delay D into {D / lanes, D % lanes}; lanes is a power of two.
  function automatic delay_split_t delay_split(input int d, input int lanes);
    delay_split_t s;
    s.q = 16'(d / lanes);
    s.r = 16'(d % lanes);
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddl_history_buf.sv
`default_nettype none
// ============================================================================
//  Module   : ddl_history_buf
//  Brief    : Ring of past input beats with one write port and two
//             asynchronous read ports (beats i-q and i-q-1).
//  Revision : 1.0 - initial release
// ============================================================================
module ddl_history_buf
  import ddl_pkg::*;
#(
  parameter int BEAT_W = 256,
  parameter int DEPTH  = 17,
  parameter int PW     = 5
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              wr_en,
  input  logic [PW-1:0]     wptr,
  input  logic [BEAT_W-1:0] wdata,
  input  logic [PW-1:0]     raddr_cur,
  output logic [BEAT_W-1:0] rdata_cur,
  input  logic [PW-1:0]     raddr_prev,
  output logic [BEAT_W-1:0] rdata_prev
);

  logic [BEAT_W-1:0] mem_q [DEPTH];

  // Storage: cleared on reset so that history starts as silence.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wptr] <= wdata;
    end
  end

  assign rdata_cur  = mem_q[raddr_cur];
  assign rdata_prev = mem_q[raddr_prev];

endmodule
`default_nettype wire

// File: rtl/ddl_frac_delay.sv
`default_nettype none
// ============================================================================
//  Module   : ddl_frac_delay
//  Brief    : AXI-Stream multi-lane delay line with a runtime-programmable
//             delay in samples (not beats). One output beat per input beat,
//             single output register, 1-cycle latency.
//             Optional macro DDL_TLAST_EN adds tlast pass-through and restarts
//             zero fill at every packet boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module ddl_frac_delay
  import ddl_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int SAMPLE_W  = 16,
  parameter int MAX_DELAY = 255
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_LANES*SAMPLE_W-1:0]   s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
`ifdef DDL_TLAST_EN
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tlast,
`endif
  output logic [NUM_LANES*SAMPLE_W-1:0]   m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  input  logic [$clog2(MAX_DELAY+1)-1:0]  cfg_delay,
  input  logic                            cfg_wr,
  output logic [$clog2(MAX_DELAY+1)-1:0]  cur_delay
);

  localparam int BW          = NUM_LANES * SAMPLE_W;
  localparam int DW          = $clog2(MAX_DELAY + 1);
  localparam int LW          = $clog2(NUM_LANES);
  localparam int DEPTH_BEATS = MAX_DELAY / NUM_LANES + 2;
  localparam int PW          = ddl_width(DEPTH_BEATS);
  localparam int CW          = ddl_width(DEPTH_BEATS + 1);

  // Ring index 'back' beats behind ptr.
  function automatic logic [PW-1:0] ring_back(input logic [PW-1:0] ptr, input int back);
    int idx;
    idx = int'(ptr) - back;
    if (idx < 0) idx = idx + DEPTH_BEATS;
    return PW'(idx);
  endfunction

  // Source lane of output lane k when the stream is shifted by r lanes.
  function automatic logic [LW-1:0] lane_of(input int k, input int r);
    return LW'((k - r + NUM_LANES) % NUM_LANES);
  endfunction

  logic              m_valid_q, m_valid_d;
  logic [BW-1:0]     m_data_q, m_data_d;
  logic [DW-1:0]     cur_delay_q, cur_delay_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              accept;
  logic              pkt_end;
  delay_split_t      split;
  logic [PW-1:0]     raddr_cur, raddr_prev;
  logic [BW-1:0]     rdata_cur, rdata_prev;
  logic [BW-1:0]     beat_cur;
  logic              ok_cur, ok_prev;
  logic [BW-1:0]     mapped;

  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

`ifdef DDL_TLAST_EN
  logic tlast_q, tlast_d;
  assign pkt_end      = s_axis_tlast;
  assign m_axis_tlast = tlast_q;

  // tlast rides alongside its beat through the output register.
  always_comb begin
    tlast_d = tlast_q;
    if (accept) tlast_d = s_axis_tlast;
  end

  // tlast register.
  always_ff @(posedge aclk) begin
    if (areset) tlast_q <= 1'b0;
    else        tlast_q <= tlast_d;
  end
`else
  assign pkt_end = 1'b0;
`endif

  // The delay in effect for the beat being accepted this cycle.
  assign split = delay_split(int'(cur_delay_q), NUM_LANES);

  assign raddr_cur  = ring_back(wptr_q, int'(split.q));
  assign raddr_prev = ring_back(wptr_q, int'(split.q) + 1);

  ddl_history_buf #(
    .BEAT_W (BW),
    .DEPTH  (DEPTH_BEATS),
    .PW     (PW)
  ) u_hist (
    .aclk       (aclk),
    .areset     (areset),
    .wr_en      (accept),
    .wptr       (wptr_q),
    .wdata      (s_axis_tdata),
    .raddr_cur  (raddr_cur),
    .rdata_cur  (rdata_cur),
    .raddr_prev (raddr_prev),
    .rdata_prev (rdata_prev)
  );

  // With q == 0 the "current" source beat is the one on the input bus.
  assign beat_cur = (split.q == '0) ? s_axis_tdata : rdata_cur;

  // A source beat exists only if it was accepted since reset/packet start.
  assign ok_cur  = int'(split.q) <= int'(cnt_q);
  assign ok_prev = (int'(split.q) + 1) <= int'(cnt_q);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic          use_prev;
    logic [LW-1:0] src_lane;
    logic [BW-1:0] src_beat;
    logic          src_ok;
    assign use_prev = (k < int'(split.r));
    assign src_lane = lane_of(k, int'(split.r));
    assign src_beat = use_prev ? rdata_prev : beat_cur;
    assign src_ok   = use_prev ? ok_prev : ok_cur;
    assign mapped[k*SAMPLE_W +: SAMPLE_W] =
      src_ok ? src_beat[src_lane*SAMPLE_W +: SAMPLE_W] : '0;
  end

  // Next-state: output register, write pointer, beat counter, delay config.
  always_comb begin
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    cur_delay_d = cur_delay_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = mapped;
      wptr_d    = (int'(wptr_q) == DEPTH_BEATS - 1) ? '0 : wptr_q + 1'b1;
      if (pkt_end)                          cnt_d = '0;
      else if (int'(cnt_q) < DEPTH_BEATS)   cnt_d = cnt_q + 1'b1;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    if (cfg_wr) begin
      cur_delay_d = (int'(cfg_delay) > MAX_DELAY) ? DW'(MAX_DELAY) : cfg_delay;
    end
  end

  // State registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      cur_delay_q <= '0;
      wptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      cur_delay_q <= cur_delay_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign cur_delay     = cur_delay_q;

endmodule
`default_nettype wire
